// File: rtl/instr_fetch_unit.sv
// Decoupled instruction-fetch front end: prefetches word-addressed instructions
// over a req/ack port into a small FIFO, flushing and refetching on redirect.
module instr_fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    instr_valid,
    output logic [DATA_W-1:0]       instr,
    output logic [ADDR_W-1:0]       instr_pc,
    input  logic                    instr_ready,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt, mem_addr_nxt;
    logic                mem_req_nxt;
    logic                push, pop;
    logic [CW-1:0]       count_after;

    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [ADDR_W-1:0]   pc_q   [DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;

    assign instr_valid = (fifo_count != '0);
    assign instr       = data_q[rd_ptr];
    assign instr_pc    = pc_q[rd_ptr];
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    // Occupancy after a push this cycle, net of any same-cycle pop.
    assign count_after = fifo_count + CW'(1) - CW'(pop);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        mem_req_nxt  = mem_req;
        mem_addr_nxt = mem_addr;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                end else if (fifo_count < FULL) begin
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = fetch_pc;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                    if (mem_ack) begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt   = DROP;
                    end
                end else if (mem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = mem_addr + 1'b1;
                    if (count_after < FULL) begin
                        mem_addr_nxt = mem_addr + 1'b1;
                    end else begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) fetch_pc_nxt = redirect_pc;
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                mem_req_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            fetch_pc   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            mem_req  <= mem_req_nxt;
            mem_addr <= mem_addr_nxt;
            if (redirect_valid) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            data_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= mem_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: wait-state memory model, scoreboard consumer,
// redirect vector table and hand-written flush/reset/backpressure sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  fifo_count;

    instr_fetch_unit #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Memory: mem[i] = i + 100, acks after 'waits' stall cycles.
    int waits = 0;
    int wcnt  = 0;
    int ack_cnt = 0;
    assign mem_ack   = mem_req && (wcnt >= waits);
    assign mem_rdata = mem_addr + 32'd100;
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
        if (mem_req && mem_ack) ack_cnt <= ack_cnt + 1;
    end

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    typedef struct { logic [31:0] pc; int waits; int n; } vec_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic en_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc  = pc + 32'(i);
            e.ins = pc + 32'(i) + 32'd100;
            q.push_back(e);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        q.delete();
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (q.size() > 0 && c < budget) begin
            tick(1);
            c++;
        end
        check("drain_done", 64'(q.size()), 64'd0);
    endtask

    // Consumer: decides ready at the negedge and scores the pop at the next posedge.
    initial begin
        exp_t e;
        instr_ready = 1'b0;
        forever begin
            @(negedge clk);
            instr_ready = en_ready && (q.size() > 0);
            if (reset_n && !redirect_valid && instr_valid && instr_ready) begin
                e = q.pop_front();
                check("sb_pc", 64'(instr_pc), 64'(e.pc));
                check("sb_instr", 64'(instr), 64'(e.ins));
            end
        end
    end

    vec_t vecs[5];
    int   base;
    int   bound;

    initial begin
        vecs[0] = '{pc: 32'h0000_1000, waits: 0, n: 6};
        vecs[1] = '{pc: 32'h0000_2000, waits: 1, n: 4};
        vecs[2] = '{pc: 32'hFFFF_FFFF, waits: 0, n: 3};
        vecs[3] = '{pc: 32'hFFFF_FFFE, waits: 2, n: 4};
        vecs[4] = '{pc: 32'h0000_0007, waits: 3, n: 3};

        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        en_ready = 1'b1; waits = 0;
        tick(2);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);

        // Zero-wait streaming from reset release.
        push_exp(32'd0, 8);
        reset_n = 1'b1;
        tick(1);
        check("s1_req", 64'(mem_req), 64'd1);
        check("s1_addr0", 64'(mem_addr), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check("s1_addr", 64'(mem_addr), 64'(k));
            check("s1_valid", 64'(instr_valid), 64'd1);
        end
        drain(50);

        // Backpressure: fill, then one pop frees one slot.
        en_ready = 1'b0;
        do_redirect(32'd0);
        base = ack_cnt;
        tick(12);
        check("fill_acks", 64'(ack_cnt - base), 64'd4);
        check("fill_req", 64'(mem_req), 64'd0);
        check("fill_count", 64'(fifo_count), 64'd4);
        push_exp(32'd0, 5);
        en_ready = 1'b1;
        tick(1);
        en_ready = 1'b0;
        tick(1);
        check("fill_req4", 64'(mem_req), 64'd1);
        check("fill_addr4", 64'(mem_addr), 64'd4);
        en_ready = 1'b1;
        drain(50);

        // Redirect while waiting on addr 2: request held, data dropped.
        en_ready = 1'b0;
        waits = 3;
        do_redirect(32'd0);
        bound = 0;
        while (!(mem_req && mem_addr == 32'd2) && bound < 60) begin
            tick(1);
            bound++;
        end
        check("drop_reach", 64'(mem_req && mem_addr == 32'd2), 64'd1);
        en_ready = 1'b1;
        do_redirect(32'h40);
        push_exp(32'h40, 3);
        check("drop_hold_req", 64'(mem_req), 64'd1);
        check("drop_hold_addr", 64'(mem_addr), 64'd2);
        for (int k = 0; k < 2; k++) begin
            tick(1);
            check("drop_hold_addr", 64'(mem_addr), 64'd2);
        end
        tick(2);
        check("drop_new_req", 64'(mem_req), 64'd1);
        check("drop_new_addr", 64'(mem_addr), 64'h40);
        drain(60);

        // Redirect coinciding with an ack and a pop.
        waits = 0;
        en_ready = 1'b1;
        do_redirect(32'h100);
        push_exp(32'h100, 100);
        tick(5);
        check("coll_pre", 64'(mem_ack && instr_valid && instr_ready), 64'd1);
        do_redirect(32'h200);
        push_exp(32'h200, 4);
        check("coll_count", 64'(fifo_count), 64'd0);
        check("coll_valid", 64'(instr_valid), 64'd0);
        check("coll_req", 64'(mem_req), 64'd0);
        tick(1);
        check("coll_req2", 64'(mem_req), 64'd1);
        check("coll_addr", 64'(mem_addr), 64'h200);
        drain(50);

        // Vector table: redirect targets (incl. address wrap) and memory speeds.
        for (int v = 0; v < 5; v++) begin
            en_ready = 1'b1;
            waits = vecs[v].waits;
            do_redirect(vecs[v].pc);
            push_exp(vecs[v].pc, vecs[v].n);
            drain(200);
        end

        // Reset while busy with two entries buffered.
        en_ready = 1'b0;
        waits = 3;
        do_redirect(32'h50);
        bound = 0;
        while (!(fifo_count == 3'd2 && mem_req) && bound < 100) begin
            tick(1);
            bound++;
        end
        check("rst2_reach", 64'(fifo_count == 3'd2 && mem_req), 64'd1);
        reset_n = 1'b0;
        q.delete();
        tick(1);
        reset_n = 1'b1;
        check("rst2_req", 64'(mem_req), 64'd0);
        check("rst2_valid", 64'(instr_valid), 64'd0);
        check("rst2_count", 64'(fifo_count), 64'd0);
        tick(1);
        check("rst2_req1", 64'(mem_req), 64'd1);
        check("rst2_addr", 64'(mem_addr), 64'd0);
        en_ready = 1'b1;
        push_exp(32'd0, 3);
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Decoupled instruction-fetch front end that sits directly upstream of the multicycle CPU's decode stage. It prefetches word-addressed instructions from instruction memory over a req/ack interface and buffers them in a small FIFO. It presents {pc, instr} to the consumer with a valid/ready handshake, and flushes and refetches when the CPU redirects on a jump, branch or jr. Addresses are word indices: sequential fetch is pc+1, matching the CPU's PC convention.

Parameters:
DEPTH, 4, FIFO entries; must be a power of two and at least 2
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  synchronous active-low reset
redirect_valid  in  1  one-cycle pulse; flush the pipeline and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address, word index
mem_req  out  1  memory read request; held high until mem_ack
mem_addr  out  ADDR_W  read address; stable while mem_req is high
mem_ack  in  1  read complete, sampled only while mem_req is high
mem_rdata  in  DATA_W  read data, valid with mem_ack
instr_valid  out  1  FIFO head holds a valid instruction
instr  out  DATA_W  instruction at the FIFO head
instr_pc  out  ADDR_W  word address of instr
instr_ready  in  1  consumer accepts the head when this and instr_valid are both high
fifo_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: when reset_n is low at a clock edge, the following values apply. fetch_pc=0, FIFO empty, fifo_count=0, instr_valid=0, mem_req=0, mem_addr=0, state=IDLE. Reset overrides all other inputs. Reset mid-transaction abandons the request; the memory must tolerate mem_req falling without an ack.
- All outputs are registered. instr, instr_pc and instr_valid are driven from the FIFO head.
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding; its data is wanted.
  - DROP: request outstanding; its data is stale.
- Issue rule: in IDLE, if (fifo_count + 0) < DEPTH and there is no redirect, set mem_req=1 and mem_addr=fetch_pc, and go to BUSY. The request slot counts as reserved, so an issued request always has FIFO room.
- BUSY with mem_ack:
  - Push {mem_addr, mem_rdata} into the FIFO and set fetch_pc = mem_addr + 1 (mod 2^ADDR_W).
  - If space remains after the push (counting any same-cycle pop), keep mem_req=1 and set mem_addr to the new fetch_pc. This allows back-to-back fetches at one per cycle with a zero-wait memory.
  - Otherwise drop mem_req and go to IDLE.
- BUSY without ack: hold mem_req and mem_addr unchanged.
- Redirect has priority over pop, push and issue:
  - Clear the FIFO in the same cycle. A same-cycle pop and a same-cycle ack push are both discarded.
  - Set fetch_pc=redirect_pc.
  - If in BUSY with no ack this cycle, go to DROP and keep mem_req/mem_addr stable.
  - If in BUSY with ack this cycle, or in IDLE, drop mem_req and go to IDLE. The new address issues on the following cycle.
- DROP: hold the request until mem_ack. Discard the data, drop mem_req and go to IDLE. A further redirect while in DROP only updates fetch_pc.
- Latency: for a redirect at edge E with no outstanding request, mem_req/mem_addr=redirect_pc appear after E+1. With a 1-cycle memory the ack arrives at E+2 and instr_valid rises after E+2.
- FIFO:
  - Pop when instr_valid && instr_ready.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
  - fifo_count never exceeds DEPTH. A push when full cannot occur, because of the reservation rule.
- The consumer sees instructions strictly in fetch order. No instruction fetched before a redirect is visible after it.

Test Plan:
- Reset release with 1-cycle-ack memory (mem[i]=i+100) and instr_ready=1 → mem_addr 0,1,2,… on consecutive cycles; instr_valid continuous; (instr_pc, instr) = (0,100), (1,101), …
- instr_ready=0 with DEPTH=4 → exactly 4 acks, then mem_req=0 and fifo_count=4. Raising ready for 1 cycle → one pop and one new request at addr 4; ordering is preserved.
- 3-wait-state memory, redirect_pc=0x40 while BUSY at addr 2 → mem_addr stays 2 until ack. That data is never output; the next request is at 0x40, and the first output has instr_pc=0x40.
- Redirect in the same cycle as an ack and an instr_ready pop → FIFO is empty next cycle and fifo_count=0. The acked word is discarded; the next request is at redirect_pc.
- fetch_pc=0xFFFFFFFF via redirect → consecutive outputs carry instr_pc 0xFFFFFFFF then 0x00000000.
- reset_n low for 1 cycle while BUSY with 2 entries buffered → next cycle mem_req=0, instr_valid=0, fifo_count=0. The fetch restarts at addr 0.
